// File: rtl/rvv_decode_seq_if.sv
// rvv_decode_seq_if: Command Queue / Uops Queue side signals of the decode sequencer.
interface rvv_decode_seq_if #(
  parameter int NUM_DE_UOP = 4,
  parameter int MAX_UOP = 8,
  parameter int INST_W = 64,
  parameter int IDX_W = $clog2(MAX_UOP)
);
  logic inst_valid_cq2de;
  logic [INST_W-1:0] inst_cq2de;
  logic [IDX_W:0] inst_uop_num_cq2de;
  logic inst_vill_cq2de;
  logic inst_pop_de2cq;
  logic [$clog2(NUM_DE_UOP):0] uq_free_uq2de;
  logic flush;
  logic [NUM_DE_UOP-1:0] uop_valid_de2uq;
  logic [NUM_DE_UOP-1:0][INST_W-1:0] uop_inst_de2uq;
  logic [NUM_DE_UOP-1:0][IDX_W-1:0] uop_index_de2uq;
  logic [NUM_DE_UOP-1:0] uop_last_de2uq;
  logic illegal_drop;
  modport master (
    output inst_valid_cq2de, inst_cq2de, inst_uop_num_cq2de, inst_vill_cq2de, uq_free_uq2de, flush,
    input inst_pop_de2cq, uop_valid_de2uq, uop_inst_de2uq, uop_index_de2uq, uop_last_de2uq, illegal_drop
  );
  modport slave (
    input inst_valid_cq2de, inst_cq2de, inst_uop_num_cq2de, inst_vill_cq2de, uq_free_uq2de, flush,
    output inst_pop_de2cq, uop_valid_de2uq, uop_inst_de2uq, uop_index_de2uq, uop_last_de2uq, illegal_drop
  );
endinterface

// File: rtl/rvv_decode_seq.sv
// rvv_decode_seq: splits the head command into uops for the Uops Queue, up to NUM_DE_UOP per cycle.
// Define RVV_DECODE_SEQ_ILLEGAL_CNT_EN to add the saturating illegal_cnt port.
module rvv_decode_seq #(
  parameter int NUM_DE_UOP = 4,
  parameter int MAX_UOP = 8,
  parameter int INST_W = 64,
  parameter int IDX_W = $clog2(MAX_UOP)
) (
  input logic clk,
  input logic rst,
`ifdef RVV_DECODE_SEQ_ILLEGAL_CNT_EN
  output logic [15:0] illegal_cnt,
`endif
  rvv_decode_seq_if.slave bus
);
  localparam int CW = IDX_W + 1;
  logic [IDX_W-1:0] idx_base, idx_next;
  logic [CW-1:0] num, remain, free_c, n;
  logic legal, go, done, drop;
  assign num = bus.inst_uop_num_cq2de;
  assign legal = !bus.inst_vill_cq2de && num != '0 && num <= CW'(MAX_UOP);
  assign free_c = CW'(bus.uq_free_uq2de) > CW'(NUM_DE_UOP) ? CW'(NUM_DE_UOP) : CW'(bus.uq_free_uq2de);
  assign remain = num - CW'(idx_base);
  assign n = remain < free_c ? remain : free_c;
  assign go = !rst && !bus.flush && bus.inst_valid_cq2de && legal;
  // illegal commands are only discarded from IDLE; mid-split they are a protocol error
  assign drop = !rst && !bus.flush && bus.inst_valid_cq2de && !legal && idx_base == '0;
  assign done = go && n == remain;
  always_ff @(posedge clk)
    if (rst) idx_base <= '0;
    else idx_base <= idx_next;
  always_comb begin
    idx_next = bus.flush || done ? '0 : go ? idx_base + n[IDX_W-1:0] : idx_base;
  end
  always_comb begin
    bus.inst_pop_de2cq = done || drop;
    bus.illegal_drop = drop;
    for (int i = 0; i < NUM_DE_UOP; i++) begin
      bus.uop_valid_de2uq[i] = go && CW'(i) < n;
      bus.uop_inst_de2uq[i] = bus.inst_cq2de;
      bus.uop_index_de2uq[i] = idx_base + IDX_W'(i);
      bus.uop_last_de2uq[i] = go && CW'(i) < n && CW'(idx_base) + CW'(i) == num - CW'(1);
    end
  end
`ifdef RVV_DECODE_SEQ_ILLEGAL_CNT_EN
  always_ff @(posedge clk)
    if (rst) illegal_cnt <= '0;
    else if (drop && illegal_cnt != 16'hffff) illegal_cnt <= illegal_cnt + 16'd1;
`endif
`ifdef ASSERT_ON
  logic [INST_W-1:0] inst_q;
  logic [CW-1:0] num_q;
  always_ff @(posedge clk) begin
    inst_q <= bus.inst_cq2de;
    num_q <= num;
    if (!rst && drop) $error("illegal instruction discarded");
    if (!rst && idx_base != '0 && !bus.inst_valid_cq2de) $error("inst_valid_cq2de dropped mid-split");
    if (!rst && idx_base != '0 && (bus.inst_cq2de != inst_q || num != num_q)) $error("instruction changed mid-split");
  end
`endif
endmodule

// File: tb/tb_rvv_decode_seq.sv
// tb_rvv_decode_seq: scoreboard bench for rvv_decode_seq (NUM_DE_UOP=4, MAX_UOP=8).
module tb_rvv_decode_seq;
  localparam int N = 4;
  localparam int M = 8;
  localparam int W = 64;
  localparam int IW = 3;
  typedef struct packed {
    logic [W-1:0] inst;
    logic [IW-1:0] idx;
    logic last;
  } uop_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  uop_t sb[$];
  rvv_decode_seq_if #(.NUM_DE_UOP(N), .MAX_UOP(M), .INST_W(W), .IDX_W(IW)) bus ();
`ifdef RVV_DECODE_SEQ_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt;
  int exp_cnt = 0;
`endif
  rvv_decode_seq #(.NUM_DE_UOP(N), .MAX_UOP(M), .INST_W(W), .IDX_W(IW)) dut (
    .clk(clk),
    .rst(rst),
`ifdef RVV_DECODE_SEQ_ILLEGAL_CNT_EN
    .illegal_cnt(illegal_cnt),
`endif
    .bus(bus.slave)
  );
  always #5 clk = ~clk;

  always @(negedge clk) begin
    uop_t e, a;
    if (!rst)
      for (int i = 0; i < N; i++)
        if (bus.uop_valid_de2uq[i]) begin
          n_chk++;
          a = {bus.uop_inst_de2uq[i], bus.uop_index_de2uq[i], bus.uop_last_de2uq[i]};
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_uop lane %0d got idx %0d last %0d, expected no uop", i, a.idx, a.last);
          end else begin
            e = sb.pop_front();
            if (a !== e) begin
              n_fail++;
              $display("FAIL uop lane %0d got inst %h idx %0d last %0d, expected inst %h idx %0d last %0d",
                       i, a.inst, a.idx, a.last, e.inst, e.idx, e.last);
            end
          end
        end
  end

  task automatic expect_uops(input logic [W-1:0] inst, input int lo, input int hi, input int num);
    uop_t u;
    for (int i = lo; i <= hi; i++) begin
      u.inst = inst;
      u.idx = IW'(i);
      u.last = (i == num - 1);
      sb.push_back(u);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] inst, input logic [IW:0] num,
                       input logic vill, input logic [2:0] free, input logic fl);
    @(posedge clk);
    #1;
    bus.inst_valid_cq2de = v;
    bus.inst_cq2de = inst;
    bus.inst_uop_num_cq2de = num;
    bus.inst_vill_cq2de = vill;
    bus.uq_free_uq2de = free;
    bus.flush = fl;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 64'h1234, 4'd8, 1'b0, 3'd4, 1'b0);
    n_chk += 4;
    if (bus.uop_valid_de2uq !== 4'b0) begin n_fail++; $display("FAIL reset_valid got %b expected 0000", bus.uop_valid_de2uq); end
    if (bus.inst_pop_de2cq !== 1'b0) begin n_fail++; $display("FAIL reset_pop got %b expected 0", bus.inst_pop_de2cq); end
    if (bus.illegal_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop got %b expected 0", bus.illegal_drop); end
    if (dut.idx_base !== 3'd0) begin n_fail++; $display("FAIL reset_idx_base got %0d expected 0", dut.idx_base); end
`ifdef RVV_DECODE_SEQ_ILLEGAL_CNT_EN
    n_chk++;
    if (illegal_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d expected 0", illegal_cnt); end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.inst_valid_cq2de = 1'b0;
  endtask

  task automatic test_full_split();
    logic [W-1:0] a = {$urandom, $urandom};
    logic [W-1:0] b = {$urandom, $urandom};
    expect_uops(a, 0, 7, 8);
    drive(1'b1, a, 4'd8, 1'b0, 3'd4, 1'b0);
    n_chk += 2;
    if (bus.uop_valid_de2uq !== 4'b1111) begin n_fail++; $display("FAIL full_c0_valid got %b expected 1111", bus.uop_valid_de2uq); end
    if (bus.inst_pop_de2cq !== 1'b0) begin n_fail++; $display("FAIL full_c0_pop got %b expected 0", bus.inst_pop_de2cq); end
    drive(1'b1, a, 4'd8, 1'b0, 3'd4, 1'b0);
    n_chk += 3;
    if (bus.uop_valid_de2uq !== 4'b1111) begin n_fail++; $display("FAIL full_c1_valid got %b expected 1111", bus.uop_valid_de2uq); end
    if (bus.inst_pop_de2cq !== 1'b1) begin n_fail++; $display("FAIL full_c1_pop got %b expected 1", bus.inst_pop_de2cq); end
    if (dut.idx_base !== 3'd4) begin n_fail++; $display("FAIL full_c1_idx_base got %0d expected 4", dut.idx_base); end
    expect_uops(b, 0, 1, 2);
    drive(1'b1, b, 4'd2, 1'b0, 3'd4, 1'b0);
    n_chk += 3;
    if (bus.uop_valid_de2uq !== 4'b0011) begin n_fail++; $display("FAIL b2b_valid got %b expected 0011", bus.uop_valid_de2uq); end
    if (bus.inst_pop_de2cq !== 1'b1) begin n_fail++; $display("FAIL b2b_pop got %b expected 1", bus.inst_pop_de2cq); end
    if (dut.idx_base !== 3'd0) begin n_fail++; $display("FAIL b2b_idx_base got %0d expected 0", dut.idx_base); end
    drive(1'b0, '0, 4'd0, 1'b0, 3'd4, 1'b0);
  endtask

  task automatic test_free_pattern();
    logic [W-1:0] c = {$urandom, $urandom};
    expect_uops(c, 0, 2, 3);
    drive(1'b1, c, 4'd3, 1'b0, 3'd1, 1'b0);
    n_chk += 2;
    if (bus.uop_valid_de2uq !== 4'b0001) begin n_fail++; $display("FAIL free1_valid got %b expected 0001", bus.uop_valid_de2uq); end
    if (bus.inst_pop_de2cq !== 1'b0) begin n_fail++; $display("FAIL free1_pop got %b expected 0", bus.inst_pop_de2cq); end
    drive(1'b1, c, 4'd3, 1'b0, 3'd0, 1'b0);
    n_chk += 3;
    if (bus.uop_valid_de2uq !== 4'b0000) begin n_fail++; $display("FAIL free0_valid got %b expected 0000", bus.uop_valid_de2uq); end
    if (bus.inst_pop_de2cq !== 1'b0) begin n_fail++; $display("FAIL free0_pop got %b expected 0", bus.inst_pop_de2cq); end
    if (dut.idx_base !== 3'd1) begin n_fail++; $display("FAIL free0_idx_base got %0d expected 1", dut.idx_base); end
    drive(1'b1, c, 4'd3, 1'b0, 3'd2, 1'b0);
    n_chk += 3;
    if (bus.uop_valid_de2uq !== 4'b0011) begin n_fail++; $display("FAIL free2_valid got %b expected 0011", bus.uop_valid_de2uq); end
    if (bus.inst_pop_de2cq !== 1'b1) begin n_fail++; $display("FAIL free2_pop got %b expected 1", bus.inst_pop_de2cq); end
    if (dut.idx_base !== 3'd1) begin n_fail++; $display("FAIL free2_idx_base got %0d expected 1", dut.idx_base); end
    drive(1'b0, '0, 4'd0, 1'b0, 3'd4, 1'b0);
    n_chk++;
    if (dut.idx_base !== 3'd0) begin n_fail++; $display("FAIL free_end_idx_base got %0d expected 0", dut.idx_base); end
  endtask

  task automatic test_clamp();
    logic [W-1:0] d = {$urandom, $urandom};
    expect_uops(d, 0, 7, 8);
    drive(1'b1, d, 4'd8, 1'b0, 3'd7, 1'b0);
    n_chk++;
    if (bus.uop_valid_de2uq !== 4'b1111) begin n_fail++; $display("FAIL clamp_valid got %b expected 1111", bus.uop_valid_de2uq); end
    drive(1'b1, d, 4'd8, 1'b0, 3'd7, 1'b0);
    n_chk++;
    if (bus.inst_pop_de2cq !== 1'b1) begin n_fail++; $display("FAIL clamp_pop got %b expected 1", bus.inst_pop_de2cq); end
    drive(1'b0, '0, 4'd0, 1'b0, 3'd4, 1'b0);
  endtask

  task automatic test_illegal();
    logic [2:0] vills = 3'b001;
    logic [3:0] nums[3] = '{4'd4, 4'd0, 4'd9};
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, {$urandom, $urandom}, nums[k], vills[k], 3'd4, 1'b0);
      n_chk += 3;
      if (bus.uop_valid_de2uq !== 4'b0) begin n_fail++; $display("FAIL illegal%0d_valid got %b expected 0000", k, bus.uop_valid_de2uq); end
      if (bus.inst_pop_de2cq !== 1'b1) begin n_fail++; $display("FAIL illegal%0d_pop got %b expected 1", k, bus.inst_pop_de2cq); end
      if (bus.illegal_drop !== 1'b1) begin n_fail++; $display("FAIL illegal%0d_drop got %b expected 1", k, bus.illegal_drop); end
`ifdef RVV_DECODE_SEQ_ILLEGAL_CNT_EN
      exp_cnt++;
`endif
      drive(1'b0, '0, 4'd0, 1'b0, 3'd4, 1'b0);
      n_chk += 2;
      if (bus.illegal_drop !== 1'b0) begin n_fail++; $display("FAIL illegal%0d_drop_pulse got %b expected 0", k, bus.illegal_drop); end
      if (bus.inst_pop_de2cq !== 1'b0) begin n_fail++; $display("FAIL illegal%0d_pop_pulse got %b expected 0", k, bus.inst_pop_de2cq); end
`ifdef RVV_DECODE_SEQ_ILLEGAL_CNT_EN
      n_chk++;
      if (illegal_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL illegal%0d_cnt got %0d expected %0d", k, illegal_cnt, exp_cnt); end
`endif
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] e = {$urandom, $urandom};
    expect_uops(e, 0, 3, 8);
    drive(1'b1, e, 4'd8, 1'b0, 3'd4, 1'b0);
    drive(1'b1, e, 4'd8, 1'b0, 3'd4, 1'b1);
    n_chk += 3;
    if (bus.uop_valid_de2uq !== 4'b0) begin n_fail++; $display("FAIL flush_valid got %b expected 0000", bus.uop_valid_de2uq); end
    if (bus.inst_pop_de2cq !== 1'b0) begin n_fail++; $display("FAIL flush_pop got %b expected 0", bus.inst_pop_de2cq); end
    if (dut.idx_base !== 3'd4) begin n_fail++; $display("FAIL flush_idx_base got %0d expected 4", dut.idx_base); end
    expect_uops(e, 0, 7, 8);
    drive(1'b1, e, 4'd8, 1'b0, 3'd4, 1'b0);
    n_chk += 2;
    if (dut.idx_base !== 3'd0) begin n_fail++; $display("FAIL flush_restart_idx_base got %0d expected 0", dut.idx_base); end
    if (bus.uop_valid_de2uq !== 4'b1111) begin n_fail++; $display("FAIL flush_restart_valid got %b expected 1111", bus.uop_valid_de2uq); end
    drive(1'b1, e, 4'd8, 1'b0, 3'd4, 1'b0);
    n_chk++;
    if (bus.inst_pop_de2cq !== 1'b1) begin n_fail++; $display("FAIL flush_restart_pop got %b expected 1", bus.inst_pop_de2cq); end
    drive(1'b0, '0, 4'd0, 1'b0, 3'd4, 1'b0);
  endtask

  task automatic test_reset_mid_split();
    logic [W-1:0] f = {$urandom, $urandom};
    expect_uops(f, 0, 1, 8);
    drive(1'b1, f, 4'd8, 1'b0, 3'd2, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    n_chk += 4;
    if (bus.uop_valid_de2uq !== 4'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b expected 0000", bus.uop_valid_de2uq); end
    if (bus.inst_pop_de2cq !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pop got %b expected 0", bus.inst_pop_de2cq); end
    if (bus.illegal_drop !== 1'b0) begin n_fail++; $display("FAIL rst_mid_drop got %b expected 0", bus.illegal_drop); end
    if (dut.idx_base !== 3'd2) begin n_fail++; $display("FAIL rst_mid_idx_before got %0d expected 2", dut.idx_base); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.inst_valid_cq2de = 1'b0;
    @(negedge clk);
    n_chk++;
    if (dut.idx_base !== 3'd0) begin n_fail++; $display("FAIL rst_mid_idx_after got %0d expected 0", dut.idx_base); end
`ifdef RVV_DECODE_SEQ_ILLEGAL_CNT_EN
    exp_cnt = 0;
`endif
  endtask

`ifdef RVV_DECODE_SEQ_ILLEGAL_CNT_EN
  task automatic test_cnt_saturation();
    drive(1'b1, '0, 4'd1, 1'b1, 3'd4, 1'b0);
    repeat (65540) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (illegal_cnt !== 16'hffff) begin n_fail++; $display("FAIL cnt_saturate got %h expected ffff", illegal_cnt); end
    drive(1'b0, '0, 4'd0, 1'b0, 3'd4, 1'b0);
  endtask
`endif

  initial begin
    bus.inst_valid_cq2de = 1'b0;
    bus.inst_cq2de = '0;
    bus.inst_uop_num_cq2de = '0;
    bus.inst_vill_cq2de = 1'b0;
    bus.uq_free_uq2de = 3'd4;
    bus.flush = 1'b0;
    test_reset();
    test_full_split();
    test_free_pattern();
    test_clamp();
    test_illegal();
    test_flush();
    test_reset_mid_split();
`ifdef RVV_DECODE_SEQ_ILLEGAL_CNT_EN
    test_cnt_saturation();
`endif
    @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d pending uops expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rvv_decode_seq.md
# rvv_decode_seq

Parametrised decode sequencer between the Command Queue and the Uops Queue. It holds the head instruction and splits it into `inst_uop_num` uops, emitting up to `NUM_DE_UOP` per cycle as the Uops Queue has free slots. It tracks the split index across cycles and pops the Command Queue when the last uop issues. Illegal instructions (`vill` or bad uop count) are discarded without a trap.

## Interface
- `NUM_DE_UOP`, 4: maximum uops emitted per cycle (1..8).
- `MAX_UOP`, 8: maximum uops per instruction (power of two, ≥ `NUM_DE_UOP`).
- `INST_W`, 64: width of the opaque instruction payload.
- `IDX_W`, `$clog2(MAX_UOP)`: uop index width (derived).

Ports (single clock; reset synchronous, active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `inst_valid_cq2de` in 1: head of Command Queue is valid.
- `inst_cq2de` in `INST_W`: instruction payload.
- `inst_uop_num_cq2de` in `IDX_W+1`: total uops for this instruction.
- `inst_vill_cq2de` in 1: vtype.vill of the instruction.
- `inst_pop_de2cq` out 1: Command Queue pop, one cycle per instruction.
- `uq_free_uq2de` in `$clog2(NUM_DE_UOP)+1`: free Uops Queue slots, saturated at `NUM_DE_UOP`.
- `flush` in 1: kill the in-progress instruction.
- `uop_valid_de2uq` out `NUM_DE_UOP`: per-lane valid, contiguous from lane 0.
- `uop_inst_de2uq` out `NUM_DE_UOP`×`INST_W`: payload copy per lane.
- `uop_index_de2uq` out `NUM_DE_UOP`×`IDX_W`: uop index per lane.
- `uop_last_de2uq` out `NUM_DE_UOP`: lane carries the instruction's final uop.
- `illegal_drop` out 1: pulse when an instruction is discarded.
- `illegal_cnt` out 16: saturating discard counter (present only with `RVV_DECODE_SEQ_ILLEGAL_CNT_EN`).

## Operation
- Register `idx_base` (`IDX_W`) holds the next uop index to issue. States:
  - IDLE: `idx_base`=0.
  - SPLIT: `idx_base`>0, instruction partially issued.
- An instruction is legal when `inst_vill_cq2de`=0 and 1 ≤ `inst_uop_num_cq2de` ≤ `MAX_UOP`.
- Legal, valid, no flush:
  - `remain = num − idx_base`; `n = min(remain, uq_free_uq2de, NUM_DE_UOP)`.
  - Lanes 0..n−1 are valid. Lane i gets `index = idx_base+i` and `last = (idx_base+i == num−1)`.
  - If `n == remain`: assert `inst_pop_de2cq`, next `idx_base` = 0 (IDLE).
  - Otherwise `idx_base += n` (SPLIT).
  - If `n`=0: hold state, no valid lanes.
- Illegal and valid, in IDLE: no lanes valid. Assert `inst_pop_de2cq` and `illegal_drop` for one cycle. Fires `$error` under `ASSERT_ON`.
- `flush`=1: no lanes valid, no pop, next `idx_base`=0. Flush takes priority over all emission in the same cycle. The Command Queue owner decides whether to drop the head.
- `inst_valid_cq2de` falling while in SPLIT is a protocol violation; `ASSERT_ON` check. Hardware holds `idx_base`.
- Payload and count must stay stable while in SPLIT; `ASSERT_ON` check.
- `uq_free_uq2de` > `NUM_DE_UOP` is clamped.

## Timing
- Outputs `uop_*`, `inst_pop_de2cq` and `illegal_drop` are combinational from the inputs and `idx_base`. There are no added pipeline stages.
- `idx_base` and `illegal_cnt` update on the rising `clk` edge.
- Throughput: an instruction of N uops with free ≥ `NUM_DE_UOP` takes ceil(N/`NUM_DE_UOP`) cycles. Back-to-back instructions issue with no bubble.
- Reset (sync, `rst`=1): `idx_base`=0 and `illegal_cnt`=0. While `rst` is high, all `uop_valid_de2uq`, `inst_pop_de2cq` and `illegal_drop` are forced to 0. Reset during SPLIT abandons the instruction; no partial pop.

## Configuration
- `RVV_DECODE_SEQ_ILLEGAL_CNT_EN` defined: the `illegal_cnt` port and register exist. The counter increments on each `illegal_drop`, saturates at 0xFFFF, and clears on `rst`.
- Not defined: the port and register are absent; `illegal_drop` still pulses.

## Test plan
- `NUM_DE_UOP`=4, num=8, free=4 each cycle -> cycle0 lanes 0-3 idx 0-3; cycle1 idx 4-7 with lane3 last=1 and pop=1; next instruction issues in cycle2.
- num=3, free pattern 1,0,2 -> idx 0 / none / idx 1,2 with last on idx 2 and pop in cycle2; `idx_base` sequence 1,1,0.
- `vill`=1, num=4 -> no valid lanes, pop=1 and `illegal_drop`=1 for one cycle; `illegal_cnt` 0→1 when the macro is enabled. Repeat for num=0 and num=9.
- `flush` asserted in SPLIT at `idx_base`=4 with free=4 -> zero valid lanes that cycle, no pop, `idx_base`=0 next cycle; re-presented instruction restarts at idx 0.
- `rst` asserted mid-SPLIT -> all outputs 0 while `rst` is high, `idx_base`=0 after release. Check `illegal_cnt` saturation at 0xFFFF after 65536+ drops.
